temp_calc_sequencer: RTL and testbench
======================================

Name: temp_calc_sequencer

Overview:
Multi-cycle controller that computes tempc = tc_base + tc_ref * adc_data from one 8x8 multiplier slice and one 32-bit accumulate path, reused over two cycles. Sits between the ADC sample stream and the home-system temperature consumer. Holds the calibration registers (base, ref), accepts samples with a valid/ready handshake, sequences the two partial products, and presents the result with a valid/ready handshake.

Parameters:
BASE_RST, 0, reset value of the tc_base calibration register (32-bit, unsigned).
REF_RST, 1, reset value of the tc_ref calibration register (8-bit, unsigned).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
cfg_we  in  1  calibration write strobe.
cfg_base  in  32  new tc_base value; loaded when cfg_we=1.
cfg_ref  in  8  new tc_ref value; loaded when cfg_we=1.
in_valid  in  1  adc_data is valid.
in_ready  out  1  block can accept a sample.
adc_data  in  16  unsigned ADC sample.
out_valid  out  1  tempc/ovf are valid.
out_ready  in  1  consumer accepts result.
tempc  out  32  result, unsigned, modulo 2^32.
ovf  out  1  carry out of bit 31 occurred during this result's computation.
sample_cnt  out  16  count of results delivered; wraps 0xFFFF->0.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, base_reg=BASE_RST, ref_reg=REF_RST, in_ready=1 after the edge, out_valid=0, tempc=0, ovf=0, sample_cnt=0. Reset overrides all other inputs, including a simultaneous cfg_we. An in-flight computation or undelivered result is discarded.
- Calibration: when cfg_we=1, base_reg and ref_reg load at that edge in any state.
- Operands are captured at sample acceptance, so a write during MUL_LO/MUL_HI/DONE does not affect the in-flight result.
- If cfg_we and acceptance occur on the same edge, the accepted sample uses the OLD register values. The new values apply from the next sample.
- States: IDLE, MUL_LO, MUL_HI, DONE. in_ready=1 only in IDLE, combinationally from state. out_valid=1 only in DONE.
- IDLE: on in_valid=1 at an edge, do the following at that edge (the accept edge), then go to MUL_LO:
  - capture a_reg=adc_data, r_reg=ref_reg;
  - set acc=base_reg (33-bit accumulator, bit 32 = carry);
  - set c_sticky=0.
  Otherwise remain in IDLE.
- MUL_LO (one cycle): p = r_reg * a_reg[7:0] (16-bit unsigned); acc = acc[31:0] + p; c_sticky |= carry; go to MUL_HI.
- MUL_HI (one cycle): p = r_reg * a_reg[15:8]; acc = acc[31:0] + (p << 8), zero-extended to 32 bits; c_sticky |= carry; go to DONE.
  - tempc and ovf are registered at this edge: tempc = acc[31:0], ovf = c_sticky including this step's carry.
- DONE: tempc and ovf stay stable while out_ready=0. On out_ready=1 at an edge: sample_cnt increments (wrapping), go to IDLE.
  - out_valid falls after that edge.
  - tempc and ovf keep their last value in IDLE. They are not cleared.
- Latency: acceptance at edge E -> out_valid=1 after edge E+2. Minimum of 4 clocks per sample. No bypass from DONE to IDLE acceptance on the same edge.
- in_valid while not in IDLE is ignored. The source must hold it until in_ready.
- Arithmetic: all operands are unsigned. The result wraps modulo 2^32. ovf reports the wrap; it does not saturate.

Test Plan:
- Reset, then cfg_we with base=200, ref=10; sample adc=32, out_ready=1 -> out_valid exactly 2 edges after accept, tempc=520, ovf=0, sample_cnt=1.
- base=120, ref=8, adc=32 -> 376. base=0, ref=16, adc=8 -> 128. Then adc=21 -> 336. sample_cnt=4, and in_ready is low in all non-IDLE cycles.
- Hi-byte path: base=0, ref=255, adc=0xFFFF -> tempc=16711425 (0xFEFF01), ovf=0. Then base=0xFFFFFF00, ref=1, adc=0x0100 -> tempc=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and a new adc -> tempc stable, in_ready=0, second sample not taken. Then out_ready=1 -> IDLE, and the second sample is accepted the next edge.
- Config race: cfg_we (base=1000, ref=2) on the same edge as accepting adc=5 with old base=0, ref=1 -> tempc=5. Next sample adc=5 -> 1010.
- Reset mid-op: assert rst in MUL_HI -> next cycle out_valid=0, in_ready=1, base/ref at BASE_RST/REF_RST, sample_cnt=0. Also exercise sample_cnt wrap from 0xFFFF to 0.

Source files
------------

// File: rtl/temp_calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : temp_calc_sequencer_if
// Description : Calibration, sample-in and result-out bundle for the
//               temperature calculation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface temp_calc_sequencer_if;
    logic        cfg_we;
    logic [31:0] cfg_base;
    logic [7:0]  cfg_ref;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] adc_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] tempc;
    logic        ovf;
    logic [15:0] sample_cnt;

    modport slave (
        input  cfg_we, cfg_base, cfg_ref, in_valid, adc_data, out_ready,
        output in_ready, out_valid, tempc, ovf, sample_cnt
    );

    modport master (
        output cfg_we, cfg_base, cfg_ref, in_valid, adc_data, out_ready,
        input  in_ready, out_valid, tempc, ovf, sample_cnt
    );
endinterface
`default_nettype wire

// File: rtl/temp_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : temp_calc_sequencer
// Description : Computes tempc = tc_base + tc_ref * adc_data over two cycles
//               with a single 8x8 multiplier and a 32-bit accumulate path.
// Revision    : 1.0 - initial release
// ============================================================================
module temp_calc_sequencer #(
    parameter logic [31:0] BASE_RST = 32'd0,
    parameter logic [7:0]  REF_RST  = 8'd1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    temp_calc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL_LO = 2'd1,
        S_MUL_HI = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_base;
    logic [7:0]  r_ref;
    logic [15:0] r_a;
    logic [7:0]  r_r;
    logic [32:0] r_acc;
    logic        r_sticky;
    logic [31:0] r_tempc;
    logic        r_ovf;
    logic [15:0] r_sample_cnt;

    logic [7:0]  w_mul_byte;
    logic [15:0] w_prod;
    logic [31:0] w_addend;
    logic [32:0] w_sum;

    // Shared multiplier: low byte in MUL_LO, high byte (weighted by 256) in MUL_HI.
    always_comb begin
        w_mul_byte = (r_state == S_MUL_HI) ? r_a[15:8] : r_a[7:0];
        w_prod     = {8'd0, r_r} * {8'd0, w_mul_byte};
        w_addend   = (r_state == S_MUL_HI) ? {8'd0, w_prod, 8'd0} : {16'd0, w_prod};
        w_sum      = {1'b0, r_acc[31:0]} + {1'b0, w_addend};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.in_valid)  w_state_nxt = S_MUL_LO;
            S_MUL_LO: w_state_nxt = S_MUL_HI;
            S_MUL_HI: w_state_nxt = S_DONE;
            S_DONE:   if (bus.out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base       <= BASE_RST;
            r_ref        <= REF_RST;
            r_a          <= 16'd0;
            r_r          <= 8'd0;
            r_acc        <= 33'd0;
            r_sticky     <= 1'b0;
            r_tempc      <= 32'd0;
            r_ovf        <= 1'b0;
            r_sample_cnt <= 16'd0;
        end else begin
            // Accept below reads the pre-write calibration values on a same-edge write.
            if (bus.cfg_we) begin
                r_base <= bus.cfg_base;
                r_ref  <= bus.cfg_ref;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.adc_data;
                        r_r      <= r_ref;
                        r_acc    <= {1'b0, r_base};
                        r_sticky <= 1'b0;
                    end
                end
                S_MUL_LO: begin
                    r_acc    <= w_sum;
                    r_sticky <= r_sticky | w_sum[32];
                end
                S_MUL_HI: begin
                    r_acc    <= w_sum;
                    r_sticky <= r_sticky | w_sum[32];
                    r_tempc  <= w_sum[31:0];
                    r_ovf    <= r_sticky | w_sum[32];
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.tempc      = r_tempc;
    assign bus.ovf        = r_ovf;
    assign bus.sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_temp_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_calc_sequencer
// Description : Directed bench with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_calc_sequencer;

    logic clk;
    logic rst;
    temp_calc_sequencer_if bus();

    temp_calc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic chk_en     = 1'b0;
    logic preset_req = 1'b0;

    // Reference model: result is plain wide arithmetic, timing is a phase count.
    logic [31:0] m_base;
    logic [7:0]  m_ref;
    logic [1:0]  m_phase;
    logic [63:0] m_pend;
    logic [31:0] m_tempc;
    logic        m_ovf;
    logic [15:0] m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_base  <= 32'd0;
            m_ref   <= 8'd1;
            m_phase <= 2'd0;
            m_pend  <= 64'd0;
            m_tempc <= 32'd0;
            m_ovf   <= 1'b0;
            m_cnt   <= 16'd0;
        end else begin
            if (bus.cfg_we) begin
                m_base <= bus.cfg_base;
                m_ref  <= bus.cfg_ref;
            end
            if (preset_req) m_cnt <= 16'hFFFF;
            case (m_phase)
                2'd0: if (bus.in_valid) begin
                    m_pend  <= {32'd0, m_base} + {56'd0, m_ref} * {48'd0, bus.adc_data};
                    m_phase <= 2'd1;
                end
                2'd1: m_phase <= 2'd2;
                2'd2: begin
                    m_tempc <= m_pend[31:0];
                    m_ovf   <= (m_pend >= 64'h1_0000_0000);
                    m_phase <= 2'd3;
                end
                default: if (bus.out_ready) begin
                    m_cnt   <= m_cnt + 16'd1;
                    m_phase <= 2'd0;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cfg(input logic [31:0] base, input logic [7:0] rf);
        bus.cfg_we = 1'b1; bus.cfg_base = base; bus.cfg_ref = rf;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    // Called just after the accept edge; returns just after the delivery edge.
    task automatic finish_sample(input logic [31:0] exp_t, input logic exp_o, input string nm);
        @(negedge clk);
        chk({nm, "_busy_in_ready"}, bus.in_ready, 1'b0);
        chk({nm, "_lat1_out_valid"}, bus.out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk({nm, "_lat2_out_valid"}, bus.out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk({nm, "_out_valid"}, bus.out_valid, 1'b1);
        chk({nm, "_tempc"}, bus.tempc, exp_t);
        chk({nm, "_ovf"}, bus.ovf, exp_o);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_sample(input logic [15:0] adc, input logic [31:0] exp_t,
                              input logic exp_o, input string nm);
        bus.in_valid = 1'b1; bus.adc_data = adc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        finish_sample(exp_t, exp_o, nm);
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_base = 32'd0; bus.cfg_ref = 8'd0;
        bus.in_valid = 1'b0; bus.adc_data = 16'd0; bus.out_ready = 1'b0;
        fork
            begin : cmp_proc
                forever begin
                    @(negedge clk);
                    if (chk_en) begin
                        chk("m_in_ready", bus.in_ready, m_phase == 2'd0);
                        chk("m_out_valid", bus.out_valid, m_phase == 2'd3);
                        chk("m_tempc", bus.tempc, m_tempc);
                        chk("m_ovf", bus.ovf, m_ovf);
                        chk("m_sample_cnt", bus.sample_cnt, m_cnt);
                    end
                end
            end
            begin : stim_proc
                repeat (2) @(posedge clk);
                #1; rst = 1'b0; chk_en = 1'b1;
                @(negedge clk);
                chk("rst_in_ready", bus.in_ready, 1'b1);
                chk("rst_out_valid", bus.out_valid, 1'b0);
                chk("rst_tempc", bus.tempc, 32'd0);
                chk("rst_ovf", bus.ovf, 1'b0);
                chk("rst_cnt", bus.sample_cnt, 16'd0);
                @(posedge clk); #1;

                cfg(32'd200, 8'd10);
                run_sample(16'd32, 32'd520, 1'b0, "s520");
                chk("cnt_1", bus.sample_cnt, 16'd1);
                cfg(32'd120, 8'd8);
                run_sample(16'd32, 32'd376, 1'b0, "s376");
                cfg(32'd0, 8'd16);
                run_sample(16'd8, 32'd128, 1'b0, "s128");
                run_sample(16'd21, 32'd336, 1'b0, "s336");
                chk("cnt_4", bus.sample_cnt, 16'd4);

                cfg(32'd0, 8'd255);
                run_sample(16'hFFFF, 32'h00FE_FF01, 1'b0, "hibyte");
                cfg(32'hFFFF_FF00, 8'd1);
                run_sample(16'h0100, 32'd0, 1'b1, "wrap_ovf");

                // Backpressure with a second sample already presented.
                cfg(32'd0, 8'd3);
                bus.in_valid = 1'b1; bus.adc_data = 16'd7;
                @(posedge clk); #1;
                bus.adc_data = 16'd9;
                @(posedge clk); #1;
                @(posedge clk); #1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_tempc", bus.tempc, 32'd21);
                    chk("bp_in_ready", bus.in_ready, 1'b0);
                    chk("bp_out_valid", bus.out_valid, 1'b1);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                chk("bp_idle_in_ready", bus.in_ready, 1'b1);
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                finish_sample(32'd27, 1'b0, "bp_second");

                // Calibration write on the accept edge.
                cfg(32'd0, 8'd1);
                bus.cfg_we = 1'b1; bus.cfg_base = 32'd1000; bus.cfg_ref = 8'd2;
                bus.in_valid = 1'b1; bus.adc_data = 16'd5;
                @(posedge clk); #1;
                bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
                finish_sample(32'd5, 1'b0, "race_old");
                run_sample(16'd5, 32'd1010, 1'b0, "race_new");

                // Counter wrap: preload the delivered-count register.
                @(negedge clk); #1;
                preset_req = 1'b1;
                force dut.r_sample_cnt = 16'hFFFF;
                @(posedge clk); #1;
                preset_req = 1'b0;
                release dut.r_sample_cnt;
                @(negedge clk);
                chk("cnt_ffff", bus.sample_cnt, 16'hFFFF);
                @(posedge clk); #1;
                run_sample(16'd3, 32'd1006, 1'b0, "cnt_wrap_s");
                chk("cnt_wrap", bus.sample_cnt, 16'd0);

                // Reset while in MUL_HI.
                bus.in_valid = 1'b1; bus.adc_data = 16'd50;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("mid_rst_out_valid", bus.out_valid, 1'b0);
                chk("mid_rst_in_ready", bus.in_ready, 1'b1);
                chk("mid_rst_cnt", bus.sample_cnt, 16'd0);
                @(posedge clk); #1;
                run_sample(16'd77, 32'd77, 1'b0, "after_rst");
                chk("after_rst_cnt", bus.sample_cnt, 16'd1);
                repeat (2) @(posedge clk);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
